kernel_conv3x3: RTL and testbench

KERNEL_CONV3X3 -- requirements
Module: kernel_conv3x3

---
 rtl/kernel_conv3x3.sv | 160 ++++++++++++++++
 tb/tb_kernel_conv3x3.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/kernel_conv3x3.sv
// ---------------------------------------------------------------------------
// kernel_conv3x3 -- streaming 3x3 Sobel / passthrough filter over a raster
// pixel stream.
//
// Two line buffers keep the previous two lines. They are RAMs addressed by the
// column counter. A 3x3 window slides along with the accepted pixels. One
// filtered result is registered for every accepted pixel whose full 3x3
// neighbourhood lies inside the frame. No border pixels are produced.
//
// Parameters
//   DATA_W  pixel width in bits (4..16)
//   LINE_W  pixels per line (3..4096)
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     start-of-frame pulse; the pixel accepted with it is (row 0, col 0)
//   in_valid  data_in carries a pixel this cycle
//   data_in   unsigned pixel, raster order
//   mode      0:|Gx|  1:|Gy|  2:|Gx|+|Gy|  3:centre passthrough
//   data_out  filtered pixel; holds its last value when valid=0
//   valid     data_out carries a new result this cycle
//
// Build option
//   KERNEL_CONV_SAT_EN  defined: magnitude results clamp to 2^DATA_W-1
//                       undefined: magnitude results wrap to DATA_W bits
// ---------------------------------------------------------------------------
module kernel_conv3x3 #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 1280
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] data_out,
    output logic              valid
);

    localparam int COL_W = $clog2(LINE_W);
    localparam int SW    = DATA_W + 4;   // signed gradient width

`ifdef KERNEL_CONV_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Line buffers: lbuf1 holds the previous line and lbuf2 the line before
    // it. They are never cleared. Stale data is kept out of the results by
    // the row/col gating.
    logic [DATA_W-1:0] lbuf1 [LINE_W];
    logic [DATA_W-1:0] lbuf2 [LINE_W];

    logic [COL_W-1:0]  col, col_cur;
    logic [1:0]        row, row_cur;
    logic [DATA_W-1:0] tap1, tap2;

    // Registered window columns 0 and 1. Column 2 is the incoming column,
    // taken straight from the pixel and the line-buffer taps, so the result
    // can be registered in the same cycle the pixel is accepted.
    logic [DATA_W-1:0] win [3][2];
    logic [DATA_W-1:0] p   [3][3];

    logic              qual;
    logic signed [SW-1:0] gx, gy;
    logic [SW-1:0]     ax, ay;
    logic [SW:0]       mag;
    logic              ovf;
    logic [DATA_W-1:0] res;

    // start overrides the stored position in the same cycle.
    assign col_cur = start ? '0 : col;
    assign row_cur = start ? '0 : row;

    assign tap1 = lbuf1[col_cur];
    assign tap2 = lbuf2[col_cur];

    assign qual = in_valid && (row_cur == 2'd2) && (col_cur >= COL_W'(2));

    function automatic logic signed [SW-1:0] ext(input logic [DATA_W-1:0] x);
        return signed'({4'b0000, x});
    endfunction

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            p[r][0] = win[r][0];
            p[r][1] = win[r][1];
        end
        p[0][2] = tap2;
        p[1][2] = tap1;
        p[2][2] = data_in;
    end

    always_comb begin
        gx = (ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2]))
           - (ext(p[0][0]) + (ext(p[1][0]) <<< 1) + ext(p[2][0]));
        gy = (ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2]))
           - (ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2]));
        ax = gx[SW-1] ? SW'(-gx) : SW'(gx);
        ay = gy[SW-1] ? SW'(-gy) : SW'(gy);
        case (mode)
            2'd0:    mag = {1'b0, ax};
            2'd1:    mag = {1'b0, ay};
            default: mag = {1'b0, ax} + {1'b0, ay};
        endcase
        ovf = |mag[SW:DATA_W];
        if (mode == 2'd3)
            res = p[1][1];
        else if (SAT_EN && ovf)
            res = {DATA_W{1'b1}};
        else
            res = mag[DATA_W-1:0];
    end

    // The line buffers are read before they are written, so lbuf2 receives
    // the value that lbuf1 held at this column.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lbuf1[col_cur] <= data_in;
            lbuf2[col_cur] <= tap1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            valid    <= 1'b0;
            data_out <= '0;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= '0;
                win[r][1] <= '0;
            end
        end else begin
            valid <= qual;
            if (qual)
                data_out <= res;
            if (in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= p[r][2];
                end
                if (col_cur == COL_W'(LINE_W - 1)) begin
                    col <= '0;
                    row <= (row_cur == 2'd2) ? 2'd2 : 2'(row_cur + 2'd1);
                end else begin
                    col <= col_cur + COL_W'(1);
                    row <= row_cur;
                end
            end else if (start) begin
                col <= '0;
                row <= '0;
            end
        end
    end

endmodule

// File: tb/tb_kernel_conv3x3.sv
// ---------------------------------------------------------------------------
// Directed testbench for kernel_conv3x3 (DATA_W=12, LINE_W=8, 4-line frames).
// The bench keeps its own copy of the frame image. It pushes the expected
// result for each qualifying pixel into a queue. The queue is popped when
// the DUT output is checked one cycle later.
// ---------------------------------------------------------------------------
module tb_kernel_conv3x3;

    localparam int DW = 12;
    localparam int LW = 8;

`ifdef KERNEL_CONV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [1:0]    mode = '0;
    logic [DW-1:0] data_out;
    logic          valid;

    kernel_conv3x3 #(.DATA_W(DW), .LINE_W(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .data_in  (data_in),
        .mode     (mode),
        .data_out (data_out),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            img [0:7][0:7];
    int            br = 0, bc = 0;
    logic [DW-1:0] q [$];
    logic [DW-1:0] last_out = '0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference result for the window centred on (r-1, c-1).
    function automatic int ref_out(input int r, input int c, input logic [1:0] m);
        int gx, gy, v;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        case (m)
            2'd0: v = iabs(gx);
            2'd1: v = iabs(gy);
            2'd2: v = iabs(gx) + iabs(gy);
            default: return img[r-1][c-1];
        endcase
        if (v > 4095) v = SAT ? 4095 : (v % 4096);
        return v;
    endfunction

    function automatic int pix_of(input int kind, input int r, input int c);
        case (kind)
            0: return 100;
            1: return (c >= 4) ? 2000 : 0;
            2: return 10*r + c;
            3: return int'($urandom_range(0, 4095));
            default: return 100 + 10*r + c;
        endcase
    endfunction

    task automatic check_out(input bit ev);
        logic [DW-1:0] e;
        checks++;
        assert (valid === ev) else begin
            errors++;
            $error("FAIL valid r%0d c%0d: observed %0b expected %0b", br, bc, valid, ev);
        end
        if (ev) begin
            e = q.pop_front();
            checks++;
            assert (data_out === e) else begin
                errors++;
                $error("FAIL data_out: observed %0d expected %0d", data_out, e);
            end
            last_out = e;
        end else begin
            checks++;
            assert (data_out === last_out) else begin
                errors++;
                $error("FAIL data_hold: observed %0d expected %0d", data_out, last_out);
            end
        end
    endtask

    task automatic px(input int pix, input logic [1:0] m, input bit st);
        bit qv;
        @(negedge clk);
        start    = st;
        in_valid = 1'b1;
        data_in  = DW'(pix);
        mode     = m;
        if (st) begin br = 0; bc = 0; end
        img[br][bc] = pix;
        qv = (br >= 2) && (bc >= 2);
        if (qv) q.push_back(DW'(ref_out(br, bc, m)));
        if (bc == LW-1) begin bc = 0; if (br < 7) br++; end
        else bc++;
        @(posedge clk); #1;
        start = 1'b0;
        check_out(qv);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = DW'($urandom_range(0, 4095));
        mode     = 2'($urandom_range(0, 3));
        @(posedge clk); #1;
        check_out(1'b0);
    endtask

    // nrows lines, the last one cut to last_cols pixels. msel 4 draws a
    // fresh mode for every pixel.
    task automatic frame(input int kind, input int msel, input bit gaps,
                         input int nrows, input int last_cols, input bit use_start);
        logic [1:0] m;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < ((r == nrows-1) ? last_cols : LW); c++) begin
                m = (msel == 4) ? 2'($urandom_range(0, 3)) : 2'(msel);
                px(pix_of(kind, r, c), m, use_start && r == 0 && c == 0);
                if (gaps) idle();
            end
        end
    endtask

    initial begin
        // Reset state.
        #1;
        checks++;
        assert (valid === 1'b0) else begin errors++; $error("FAIL rst_valid: observed %0b expected 0", valid); end
        checks++;
        assert (data_out === '0) else begin errors++; $error("FAIL rst_data: observed %0d expected 0", data_out); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle();

        frame(0, 0, 1'b0, 4, LW, 1'b1);   // flat 100, |Gx|
        frame(0, 1, 1'b0, 4, LW, 1'b1);   // flat 100, |Gy|
        frame(1, 0, 1'b0, 4, LW, 1'b1);   // vertical edge
        frame(1, 0, 1'b1, 4, LW, 1'b1);   // same edge with idle gaps
        frame(2, 3, 1'b0, 4, LW, 1'b1);   // passthrough 10*row+col
        frame(3, 4, 1'b0, 4, LW, 1'b1);   // random pixels and modes
        frame(3, 2, 1'b0, 4, LW, 1'b1);   // random pixels, |Gx|+|Gy|

        // Restart the frame at row 1, col 5.
        frame(2, 3, 1'b0, 2, 5, 1'b1);
        frame(4, 3, 1'b0, 4, LW, 1'b1);

        // Asynchronous reset in the middle of row 3, after a qualifying
        // pixel has left a non-zero result on data_out.
        frame(2, 3, 1'b0, 4, 3, 1'b1);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        assert (valid === 1'b0) else begin errors++; $error("FAIL arst_valid: observed %0b expected 0", valid); end
        checks++;
        assert (data_out === '0) else begin errors++; $error("FAIL arst_data: observed %0d expected 0", data_out); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        last_out = '0;
        br = 0;
        bc = 0;
        frame(3, 4, 1'b0, 4, LW, 1'b0);   // no start: recovery from (0,0)
        idle();

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain: observed %0d expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
